// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core's multi-cycle multiply path:
// sequencer state encoding, default operand width and counter sizing.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mult_state_e;

   localparam int MULT_WIDTH = 32;

   // Counter must hold 0..WIDTH so it can count every shift-add iteration.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Signed shift-add multiply datapath: operand magnitudes, 2*WIDTH accumulator,
// final sign fix-up into the HI/LO registers.
module mult_shift_add_dp
   import mips_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               fix,
   input  logic [CNT_W-1:0]   shamt,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam int PROD_W = 2 * WIDTH;

   logic [WIDTH-1:0]  mag_a_q, mag_a_d;
   logic [WIDTH-1:0]  mag_b_q, mag_b_d;
   logic              neg_q, neg_d;
   logic [PROD_W-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;

   always_comb begin
      mag_a_d = mag_a_q;
      mag_b_d = mag_b_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (load) begin
         // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
         mag_a_d = src_a[WIDTH-1] ? -src_a : src_a;
         mag_b_d = src_b[WIDTH-1] ? -src_b : src_b;
         neg_d   = src_a[WIDTH-1] ^ src_b[WIDTH-1];
         acc_d   = '0;
      end else if (step) begin
         if (mag_b_q[0]) begin
            acc_d = acc_q + (PROD_W'(mag_a_q) << shamt);
         end
         mag_b_d = mag_b_q >> 1;
      end else if (fix) begin
         {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mag_a_q <= '0;
         mag_b_q <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         mag_a_q <= mag_a_d;
         mag_b_q <= mag_b_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle controller for mult/mflo: sequences the shift-add datapath and
// stalls the program counter until HI/LO hold the final product.
module mult_sequencer
   import mips_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_operation,
   input  logic             mflo_flag,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             PC_En,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic [1:0]       state_dbg
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   mult_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load, step, fix;

   // mflo needs no sequencing: the stall guarantees LO is final before it issues.
   logic unused_mflo;
   assign unused_mflo = mflo_flag;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mult_operation) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            step  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            fix     = 1'b1;
            state_d = ST_DONE;
         end
         // mult_operation is still asserted here for the same instruction; ignore it.
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   mult_shift_add_dp #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_dp (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .step  (step),
      .fix   (fix),
      .shamt (cnt_q),
      .src_a (srcA),
      .src_b (srcB),
      .hi    (hi_out),
      .lo    (lo_out)
   );

   assign busy      = (state_q == ST_RUN) || (state_q == ST_FIX);
   assign done      = (state_q == ST_DONE);
   assign PC_En     = reset || !(((state_q == ST_IDLE) && mult_operation) || busy);
   assign state_dbg = state_q;

endmodule
